q_serializer: RTL and testbench
===============================

# q_serializer

Charge-to-pulse-train transmitter: accepts a charge value, converts it to a count of quantised pulses of Q_PER_PULSE each, and drives them serially on `q_serialized`. After the train it holds the line low long enough for the paired charge-measurement receiver's watchdog to expire, then reports completion. It is the stimulus/transmit end of the serialized-charge link in the measurement chain.

## Interface
Parameters:
- BUS_WIDTH, 10, width of charge input, pulse count and residue
- Q_PER_PULSE, 30, charge represented by one pulse; 1 <= Q_PER_PULSE < 2**BUS_WIDTH
- HIGH_CYCLES, 1, clocks `q_serialized` is high per pulse; >= 1
- LOW_CYCLES, 1, low clocks per pulse, excluding the check cycle; >= 1
- TRAIL_CYCLES, 8, extra low clocks after the last pulse before `done`; >= 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- q_in  in  BUS_WIDTH  charge to transmit; latched on acceptance
- q_serialized  out  1  registered pulse train
- busy  out  1  high from acceptance until `done`
- done  out  1  one-cycle completion strobe
- pulse_count  out  BUS_WIDTH  pulses sent (floor(q_in / Q_PER_PULSE)); valid with `done`, held until next `done`
- residue  out  BUS_WIDTH  q_in mod Q_PER_PULSE; valid with `done`, held until next `done`

## Operation
- States: IDLE, CHECK, HIGH, LOW, TRAIL. Internal: `rem` (BUS_WIDTH), `cnt` (BUS_WIDTH), `timer` ($clog2 of the largest cycle parameter, at least 1 bit).
- Reset (rst=0, asynchronous): state IDLE; `q_serialized`, `busy`, `done`, `pulse_count`, `residue`, `rem`, `cnt`, `timer` = 0.
- IDLE, start=1: rem<=q_in, cnt<=0, busy<=1, state<=CHECK. start=0: stay. In any state other than IDLE, start is ignored.
- CHECK, rem >= Q_PER_PULSE: q_serialized<=1, rem<=rem-Q_PER_PULSE, cnt<=cnt+1, timer<=HIGH_CYCLES-1, state<=HIGH.
- CHECK, rem < Q_PER_PULSE: timer<=TRAIL_CYCLES-1, state<=TRAIL.
- HIGH: if timer==0, q_serialized<=0, timer<=LOW_CYCLES-1, state<=LOW. Otherwise timer decrements.
- LOW: if timer==0, state<=CHECK. Otherwise timer decrements.
- TRAIL: if timer==0, done<=1, busy<=0, pulse_count<=cnt, residue<=rem, state<=IDLE. Otherwise timer decrements.
- `done` is cleared on the following edge.
- Arithmetic: division is repeated unsigned subtraction, one subtraction per pulse. No overflow is possible. cnt*Q_PER_PULSE + residue == q_in always holds.

## Timing
- Acceptance edge is E0. CHECK edges occur at E0 + 1 + k*(HIGH_CYCLES+LOW_CYCLES+1), for k = 0..P, where P = pulse count.
- Each pulse has rise-to-rise period HIGH_CYCLES+LOW_CYCLES+1; high width is HIGH_CYCLES.
- `done` is registered at edge E0 + 1 + P*(HIGH_CYCLES+LOW_CYCLES+1) + TRAIL_CYCLES.
- `q_serialized` stays low from the last falling edge until `done`. Low time is at least LOW_CYCLES+1+TRAIL_CYCLES clocks.
- Link constraint (integration rule, not checked in RTL): LOW_CYCLES+1 < 2**WTD_BUS_WIDTH of the receiver, and TRAIL_CYCLES >= 2**WTD_BUS_WIDTH+2.
- q_in=0, or q_in < Q_PER_PULSE: no pulses; done at E0+1+TRAIL_CYCLES; pulse_count=0; residue=q_in.
- start held high through `done`: the next request is accepted on the edge after `done` (state is IDLE then). There is no back-to-back acceptance on the `done` edge itself.
- start asserted while busy: ignored. It is not queued.
- q_in changes after acceptance: no effect.
- Reset mid-train: `q_serialized` drops low asynchronously; no `done` is issued; all outputs return to their reset values.

## Test plan
- Defaults, q_in=100, start pulse at E0 -> rises at E1, E4, E7; each high 1 clock; done at E18; pulse_count=3, residue=10; busy high E0..E18.
- q_in=0 -> no pulses; done at E9; pulse_count=0, residue=0.
- q_in=1023 -> 34 pulses; residue=3; done at E0+1+102+8 = E111.
- start held high continuously with q_in=60, then q_in=30 after E0 -> first done: 2 pulses, residue 0; second acceptance at the edge after done; second result 1 pulse, residue 0; pulses during busy ignored.
- rst asserted low during the second high of q_in=100 -> q_serialized=0 immediately; no done; state IDLE; fresh start with q_in=29 gives 0 pulses, residue 29.
- Loopback with the receiver (WTD_BUS_WIDTH=2, Q_PER_PULSE=30), random q_in -> receiver q_measured == q_in - residue for 200 transfers.

Source files
------------

// File: rtl/q_serializer.sv
`default_nettype none
// ============================================================================
// Module   : q_serializer
// Brief    : Converts a charge value into a serial train of quantised pulses,
//            then holds the line low long enough for the receiver watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module q_serializer #(
  parameter int BUS_WIDTH    = 10,
  parameter int Q_PER_PULSE  = 30,
  parameter int HIGH_CYCLES  = 1,
  parameter int LOW_CYCLES   = 1,
  parameter int TRAIL_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] q_in,
  output logic                 q_serialized,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] pulse_count,
  output logic [BUS_WIDTH-1:0] residue
);

  localparam int C_MAX_HL  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int C_MAX_CYC = (C_MAX_HL > TRAIL_CYCLES) ? C_MAX_HL : TRAIL_CYCLES;
  localparam int C_TW      = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

  localparam logic [BUS_WIDTH-1:0] c_qpp      = BUS_WIDTH'(Q_PER_PULSE);
  localparam logic [BUS_WIDTH-1:0] c_one      = BUS_WIDTH'(1);
  localparam logic [C_TW-1:0]      c_high_ld  = C_TW'(HIGH_CYCLES - 1);
  localparam logic [C_TW-1:0]      c_low_ld   = C_TW'(LOW_CYCLES - 1);
  localparam logic [C_TW-1:0]      c_trail_ld = C_TW'(TRAIL_CYCLES - 1);
  localparam logic [C_TW-1:0]      c_t_one    = C_TW'(1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_check = 3'd1;
  localparam logic [2:0] c_st_high  = 3'd2;
  localparam logic [2:0] c_st_low   = 3'd3;
  localparam logic [2:0] c_st_trail = 3'd4;

  logic [2:0]           r_state;
  logic [BUS_WIDTH-1:0] r_rem;
  logic [BUS_WIDTH-1:0] r_cnt;
  logic [C_TW-1:0]      r_timer;
  logic                 r_q_ser;
  logic                 r_busy;
  logic                 r_done;
  logic [BUS_WIDTH-1:0] r_pulse_count;
  logic [BUS_WIDTH-1:0] r_residue;
  logic                 w_timer_zero;

  assign w_timer_zero = (r_timer == '0);

  // Division by repeated subtraction: each CHECK with enough remaining charge
  // emits one pulse and removes one quantum, so cnt*Q + rem == q_in always.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= c_st_idle;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_timer       <= '0;
      r_q_ser       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pulse_count <= '0;
      r_residue     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_rem   <= q_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= c_st_check;
          end
        end
        c_st_check: begin
          if (r_rem >= c_qpp) begin
            r_q_ser <= 1'b1;
            r_rem   <= r_rem - c_qpp;
            r_cnt   <= r_cnt + c_one;
            r_timer <= c_high_ld;
            r_state <= c_st_high;
          end else begin
            r_timer <= c_trail_ld;
            r_state <= c_st_trail;
          end
        end
        c_st_high: begin
          if (w_timer_zero) begin
            r_q_ser <= 1'b0;
            r_timer <= c_low_ld;
            r_state <= c_st_low;
          end else begin
            r_timer <= r_timer - c_t_one;
          end
        end
        c_st_low: begin
          if (w_timer_zero) begin
            r_state <= c_st_check;
          end else begin
            r_timer <= r_timer - c_t_one;
          end
        end
        c_st_trail: begin
          // Trailing low time lets the receiver watchdog close the frame.
          if (w_timer_zero) begin
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_pulse_count <= r_cnt;
            r_residue     <= r_rem;
            r_state       <= c_st_idle;
          end else begin
            r_timer <= r_timer - c_t_one;
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_q_ser <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q_serialized = r_q_ser;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pulse_count  = r_pulse_count;
  assign residue      = r_residue;

endmodule
`default_nettype wire

// File: tb/tb_q_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_serializer
// Brief    : Scoreboard bench for q_serializer with directed charge vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_q_serializer;

  localparam int BW = 10;
  localparam int HC = 1;
  localparam int LC = 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [BW-1:0] q_in;
  logic          q_serialized;
  logic          busy;
  logic          done;
  logic [BW-1:0] pulse_count;
  logic [BW-1:0] residue;

  q_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .q_in         (q_in),
    .q_serialized (q_serialized),
    .busy         (busy),
    .done         (done),
    .pulse_count  (pulse_count),
    .residue      (residue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p;
    int r;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: measures pulse shapes and acceptance-to-done latency, pops on done.
  int npulse = 0, hi_run = 0, lo_run = 0, accept_cyc = 0;
  bit prev_q = 0, prev_busy = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      npulse = 0; hi_run = 0; lo_run = 0; prev_q = 0; prev_busy = 0;
    end else begin
      if (busy && !prev_busy) accept_cyc = cyc;
      if (q_serialized && !prev_q) begin
        if (npulse > 0) check("low_gap", lo_run, LC + 1);
        lo_run = 0;
      end
      if (q_serialized) hi_run++;
      else begin
        lo_run++;
        if (prev_q) begin
          check("high_width", hi_run, HC);
          npulse++;
          hi_run = 0;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pulse_count", int'(pulse_count), e.p);
          check("residue", int'(residue), e.r);
          check("pulses_seen", npulse, e.p);
          check("done_latency", cyc - accept_cyc, e.lat);
          check("busy_at_done", int'(busy), 0);
        end
        npulse = 0;
      end
      prev_q = q_serialized;
      prev_busy = busy;
    end
  end

  task automatic push(input int p, input int r);
    exp_t e;
    e.p = p; e.r = r; e.lat = 1 + p * (HC + LC + 1) + 8;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic send(input int q, input int p, input int r);
    @(negedge clk);
    q_in = BW'(q);
    start = 1'b1;
    push(p, r);
    @(negedge clk);
    start = 1'b0;
    q_in = ~q_in;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int rises;
    rst = 1'b0;
    start = 1'b0;
    q_in = '0;
    repeat (3) @(negedge clk);
    check("rst_q_serialized", int'(q_serialized), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pulse_count", int'(pulse_count), 0);
    check("rst_residue", int'(residue), 0);
    rst = 1'b1;
    @(negedge clk);

    send(100, 3, 10);
    send(0, 0, 0);
    send(1023, 34, 3);
    send(29, 0, 29);
    send(30, 1, 0);
    send(59, 1, 29);
    send(60, 2, 0);

    // start held high across two transfers
    @(negedge clk);
    q_in = 10'd60;
    start = 1'b1;
    push(2, 0);
    @(negedge clk);
    q_in = 10'd30;
    push(1, 0);
    wait_done();
    check("held_busy_on_done", int'(busy), 0);
    @(negedge clk);
    check("held_reaccept", int'(busy), 1);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // reset during the second high pulse of q_in=100
    q_in = 10'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0;
    for (int i = 0; i < 50 && rises < 2; i++) begin
      @(negedge clk);
      if (q_serialized) rises++;
    end
    check("second_pulse_seen", rises, 2);
    #1 rst = 1'b0;
    #1;
    check("arst_q_serialized", int'(q_serialized), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_pulse_count", int'(pulse_count), 0);
    check("arst_residue", int'(residue), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", int'(busy), 0);
    send(29, 0, 29);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
